psk_edge_slicer: RTL and testbench

PSK_EDGE_SLICER -- requirements
Module: psk_edge_slicer

---
 rtl/psk_edge_slicer.sv | 215 +++++++++++++++++++++
 tb/tb_psk_edge_slicer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/psk_edge_slicer.sv
// ---------------------------------------------------------------------------
// psk_edge_slicer
//   Slices an unsigned PSK envelope into clean logic edges. A hysteresis
//   comparator produces cmp; its rising transitions are candidate edges.
//   A small IDLE/SEARCH/TRACK tracker accepts candidates, enforcing a
//   minimum spacing between accepted edges and detecting loss of track
//   when no edge arrives within TIMEOUT clocks.
//
// Ports
//   clk            in   system clock, all state on rising edge
//   rst            in   asynchronous active-high reset
//   enable         in   1 = operate, 0 = return to IDLE
//   mode           in   0 = toggle output per edge, 1 = one-cycle pulse
//   dat            in   unsigned envelope sample
//   out            out  HIGH_VOL or LOW_VOL
//   edge_pulse     out  one-cycle strobe per accepted edge
//   edge_interval  out  clocks between the last two accepted edges
//   interval_valid out  one-cycle strobe when edge_interval updates
//   locked         out  high after LOCK_EDGES consecutive accepted edges
//   timeout        out  one-cycle strobe on loss of track
//   state_dbg      out  current tracker state (0 IDLE, 1 SEARCH, 2 TRACK)
//
// Latency: the edge that first samples dat >= THR_HI sets cmp; the next
// edge registers the candidate; the edge after that accepts it, so
// edge_pulse rises two clocks after the triggering sample.
// ---------------------------------------------------------------------------
module psk_edge_slicer #(
  parameter int                   INPUT_WIDTH = 14,
  parameter int                   OUT_WIDTH   = 14,
  parameter logic [OUT_WIDTH-1:0] HIGH_VOL    = 14'd500,
  parameter logic [OUT_WIDTH-1:0] LOW_VOL     = 14'd0,
  parameter int                   THR_HI      = 1000,
  parameter int                   THR_LO      = 600,
  parameter int                   MIN_DL_TIME = 100,
  parameter int                   TIMEOUT     = 18000,
  parameter int                   LOCK_EDGES  = 4,
  parameter int                   CNT_WIDTH   = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   mode,
  input  logic [INPUT_WIDTH-1:0] dat,
  output logic [OUT_WIDTH-1:0]   out,
  output logic                   edge_pulse,
  output logic [CNT_WIDTH-1:0]   edge_interval,
  output logic                   interval_valid,
  output logic                   locked,
  output logic                   timeout,
  output logic [1:0]             state_dbg
);

  localparam int RUN_W = $clog2(LOCK_EDGES + 1);

  localparam logic [INPUT_WIDTH-1:0] THR_HI_C  = INPUT_WIDTH'(THR_HI);
  localparam logic [INPUT_WIDTH-1:0] THR_LO_C  = INPUT_WIDTH'(THR_LO);
  localparam logic [CNT_WIDTH-1:0]   MIN_DL_C  = CNT_WIDTH'(MIN_DL_TIME);
  localparam logic [CNT_WIDTH-1:0]   TIMEOUT_C = CNT_WIDTH'(TIMEOUT);
  localparam logic [CNT_WIDTH-1:0]   ONE_C     = CNT_WIDTH'(1);
  localparam logic [RUN_W-1:0]       LOCK_C    = RUN_W'(LOCK_EDGES);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_TRACK  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic                   cmp_q, cmp_d;
  logic                   cmp_prev_q, cmp_prev_d;
  logic                   cand_q, cand_d;
  logic                   vol_q, vol_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [RUN_W-1:0]       run_q, run_d;
  logic [OUT_WIDTH-1:0]   out_q, out_d;
  logic                   edge_pulse_q, edge_pulse_d;
  logic [CNT_WIDTH-1:0]   interval_q, interval_d;
  logic                   iv_q, iv_d;
  logic                   locked_q, locked_d;
  logic                   timeout_q, timeout_d;

  logic accept;
  logic tmo_fire;

  // Comparator and candidate pipeline run regardless of enable.
  always_comb begin
    cmp_d = cmp_q;
    if (dat >= THR_HI_C) begin
      cmp_d = 1'b1;
    end else if (dat <= THR_LO_C) begin
      cmp_d = 1'b0;
    end
    cmp_prev_d = cmp_q;
    cand_d     = cmp_q & ~cmp_prev_q;
  end

  // Edge acceptance; an accepted edge always pre-empts a timeout.
  always_comb begin
    accept   = 1'b0;
    tmo_fire = 1'b0;
    if (enable && cand_q) begin
      if (state_q == ST_SEARCH) begin
        accept = 1'b1;
      end else if (state_q == ST_TRACK && cnt_q >= MIN_DL_C) begin
        accept = 1'b1;
      end
    end
    if (enable && state_q == ST_TRACK && !accept && cnt_q == TIMEOUT_C) begin
      tmo_fire = 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   state_d = ST_SEARCH;
        ST_SEARCH: if (accept) state_d = ST_TRACK;
        ST_TRACK:  if (tmo_fire) state_d = ST_SEARCH;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // Output / datapath next values
  always_comb begin
    cnt_d        = cnt_q;
    run_d        = run_q;
    vol_d        = vol_q ^ accept;
    interval_d   = interval_q;
    iv_d         = 1'b0;
    edge_pulse_d = accept;
    timeout_d    = tmo_fire;

    if (!enable || state_q == ST_IDLE) begin
      cnt_d = '0;
    end else if (accept) begin
      cnt_d = ONE_C;
    end else if (cnt_q < TIMEOUT_C) begin
      cnt_d = cnt_q + ONE_C;
    end

    if (!enable || state_q == ST_IDLE || tmo_fire) begin
      run_d = '0;
    end else if (accept && run_q < LOCK_C) begin
      run_d = run_q + RUN_W'(1);
    end

    // The first edge out of SEARCH has no predecessor to measure from.
    if (accept && state_q == ST_TRACK) begin
      interval_d = cnt_q;
      iv_d       = 1'b1;
    end

    locked_d = (run_d == LOCK_C);

    if (mode) begin
      out_d = accept ? HIGH_VOL : LOW_VOL;
    end else begin
      out_d = vol_d ? HIGH_VOL : LOW_VOL;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmp_q        <= 1'b0;
      cmp_prev_q   <= 1'b0;
      cand_q       <= 1'b0;
      vol_q        <= 1'b0;
      cnt_q        <= '0;
      run_q        <= '0;
      out_q        <= LOW_VOL;
      edge_pulse_q <= 1'b0;
      interval_q   <= '0;
      iv_q         <= 1'b0;
      locked_q     <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      cmp_q        <= cmp_d;
      cmp_prev_q   <= cmp_prev_d;
      cand_q       <= cand_d;
      vol_q        <= vol_d;
      cnt_q        <= cnt_d;
      run_q        <= run_d;
      out_q        <= out_d;
      edge_pulse_q <= edge_pulse_d;
      interval_q   <= interval_d;
      iv_q         <= iv_d;
      locked_q     <= locked_d;
      timeout_q    <= timeout_d;
    end
  end

  assign out            = out_q;
  assign edge_pulse     = edge_pulse_q;
  assign edge_interval  = interval_q;
  assign interval_valid = iv_q;
  assign locked         = locked_q;
  assign timeout        = timeout_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_psk_edge_slicer.sv
// ---------------------------------------------------------------------------
// tb_psk_edge_slicer
//   Directed sequence of scenarios with randomized levels/lengths. A
//   timestamp-based reference model predicts every output each cycle.
// ---------------------------------------------------------------------------
module tb_psk_edge_slicer;

  localparam int          IW       = 14;
  localparam int          OW       = 14;
  localparam int          CW       = 32;
  localparam logic [13:0] HI_V     = 14'd500;
  localparam logic [13:0] LO_V     = 14'd0;
  localparam int          THR_HI   = 1000;
  localparam int          THR_LO   = 600;
  localparam int          MIN_DL   = 100;
  localparam int          TMO      = 18000;
  localparam int          LOCK_N   = 4;

  localparam int MS_IDLE = 0, MS_SEARCH = 1, MS_TRACK = 2;

  // clock / reset
  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          enable = 1'b0;
  logic          mode = 1'b0;
  logic [IW-1:0] dat = '0;
  logic [OW-1:0] out;
  logic          edge_pulse;
  logic [CW-1:0] edge_interval;
  logic          interval_valid;
  logic          locked;
  logic          timeout;
  logic [1:0]    state_dbg;

  always #5 clk = ~clk;

  psk_edge_slicer dut (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .dat(dat),
    .out(out), .edge_pulse(edge_pulse), .edge_interval(edge_interval),
    .interval_valid(interval_valid), .locked(locked), .timeout(timeout),
    .state_dbg(state_dbg)
  );

  // scoreboard counters
  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int ep_seen = 0;
  int to_seen = 0;

  // reference model state (absolute edge timestamps)
  int        cyc;
  bit        m_cmp;
  int        rise_q[$];
  int        m_state;
  int        m_last;
  int        m_run;
  bit        m_vol;
  int        m_interval;
  bit        e_ep, e_iv, e_to, e_lock;
  logic [13:0] e_out;

  function automatic void model_reset();
    cyc = 0; m_cmp = 1'b0; rise_q.delete();
    m_state = MS_IDLE; m_last = 0; m_run = 0; m_vol = 1'b0;
    m_interval = 0; e_ep = 0; e_iv = 0; e_to = 0; e_lock = 0; e_out = LO_V;
  endfunction

  function automatic void model_edge(int d, bit e, bit m);
    bit cand, new_cmp, acc;
    int gap;
    cyc++;
    while (rise_q.size() > 0 && rise_q[0] < cyc - 2) void'(rise_q.pop_front());
    cand = (rise_q.size() > 0 && rise_q[0] == cyc - 2);
    if (cand) void'(rise_q.pop_front());
    new_cmp = (d >= THR_HI) ? 1'b1 : ((d <= THR_LO) ? 1'b0 : m_cmp);
    if (new_cmp && !m_cmp) rise_q.push_back(cyc);
    m_cmp = new_cmp;
    acc = 0; e_ep = 0; e_iv = 0; e_to = 0;
    if (!e) begin
      m_state = MS_IDLE; m_run = 0;
    end else if (m_state == MS_IDLE) begin
      m_state = MS_SEARCH;
    end else if (m_state == MS_SEARCH) begin
      if (cand) begin acc = 1; m_state = MS_TRACK; m_run = 1; end
    end else begin
      gap = cyc - m_last;
      if (cand && gap >= MIN_DL) begin
        acc = 1; e_iv = 1; m_interval = gap;
        m_run = (m_run < LOCK_N) ? m_run + 1 : LOCK_N;
      end else if (gap >= TMO) begin
        e_to = 1; m_state = MS_SEARCH; m_run = 0;
      end
    end
    if (acc) begin e_ep = 1; m_vol = !m_vol; m_last = cyc; end
    e_lock = (m_run >= LOCK_N);
    e_out  = m ? (acc ? HI_V : LO_V) : (m_vol ? HI_V : LO_V);
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_all();
    chk("out", 32'(out), 32'(e_out));
    chk("edge_pulse", 32'(edge_pulse), 32'(e_ep));
    chk("interval_valid", 32'(interval_valid), 32'(e_iv));
    chk("edge_interval", edge_interval, 32'(m_interval));
    chk("locked", 32'(locked), 32'(e_lock));
    chk("timeout", 32'(timeout), 32'(e_to));
    ep_seen += int'(edge_pulse);
    to_seen += int'(timeout);
  endtask

  // driver: called at a negedge, drives one cycle, checks after it
  task automatic tick(int d, bit e, bit m);
    dat = 14'(d); enable = e; mode = m;
    @(posedge clk);
    model_edge(d, e, m);
    @(negedge clk);
    check_all();
  endtask

  task automatic wave(int hv, int hl, int lv, int ll, bit m);
    for (int i = 0; i < hl; i++) tick(hv, 1'b1, m);
    for (int i = 0; i < ll; i++) tick(lv, 1'b1, m);
  endtask

  task automatic check_reset_vals(string tag);
    chk({tag, "_out"}, 32'(out), 32'(LO_V));
    chk({tag, "_edge_pulse"}, 32'(edge_pulse), 32'd0);
    chk({tag, "_edge_interval"}, edge_interval, 32'd0);
    chk({tag, "_interval_valid"}, 32'(interval_valid), 32'd0);
    chk({tag, "_locked"}, 32'(locked), 32'd0);
    chk({tag, "_timeout"}, 32'(timeout), 32'd0);
  endtask

  task automatic pulse_reset(string tag);
    rst = 1'b1;
    #1;
    model_reset();
    check_reset_vals(tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int tmo_base;
    // reset
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_reset_vals("reset");
    @(negedge clk);
    rst = 1'b0;

    // toggle mode square wave, 500-clock period
    for (int i = 0; i < 10; i++) tick(200, 1'b1, 1'b0);
    for (int p = 0; p < 6; p++) wave(1200, 250, 200, 250, 1'b0);
    chk("interval_500", edge_interval, 32'd500);
    chk("locked_after_edges", 32'(locked), 32'd1);

    // glitch 50 clocks after an accepted edge is ignored
    wave(1200, 30, 200, 20, 1'b0);
    wave(1200, 30, 200, 420, 1'b0);
    wave(1200, 10, 1200, 0, 1'b0);
    chk("interval_after_glitch", edge_interval, 32'd500);
    for (int i = 0; i < 240; i++) tick(200, 1'b1, 1'b0);

    // hysteresis: noise inside the band produces no extra edges
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 100; i++) tick(600, 1'b1, 1'b0);
      for (int i = 0; i < 100; i++) tick($urandom_range(THR_LO + 1, THR_HI - 1), 1'b1, 1'b0);
      for (int i = 0; i < 100; i++) tick(1200, 1'b1, 1'b0);
      for (int i = 0; i < 100; i++) tick($urandom_range(THR_LO + 1, THR_HI - 1), 1'b1, 1'b0);
    end

    // randomized levels, spacing and mode
    for (int r = 0; r < 20; r++) begin
      wave($urandom_range(THR_HI, 16383), $urandom_range(20, 150),
           $urandom_range(0, THR_LO), $urandom_range(20, 150),
           1'($urandom_range(0, 1)));
    end

    // lock, then starve the input until loss of track
    for (int p = 0; p < 5; p++) wave(1500, 100, 100, 100, 1'b0);
    chk("locked_before_starve", 32'(locked), 32'd1);
    tmo_base = to_seen;
    for (int i = 0; i < TMO + 5; i++) tick(0, 1'b1, 1'b0);
    chk("timeout_count", 32'(to_seen - tmo_base), 32'd1);
    chk("unlocked_after_timeout", 32'(locked), 32'd0);
    wave(1500, 20, 100, 150, 1'b0);

    // pulse mode, then back to toggle mid-stream
    for (int p = 0; p < 4; p++) wave(1500, 60, 100, 90, 1'b1);
    wave(1500, 60, 100, 40, 1'b1);
    for (int i = 0; i < 50; i++) tick(100, 1'b1, 1'b0);
    for (int p = 0; p < 3; p++) wave(1500, 60, 100, 90, 1'b0);

    // enable dropped for 10 cycles
    wave(1500, 60, 100, 30, 1'b0);
    for (int i = 0; i < 10; i++) tick(100, 1'b0, 1'b0);
    chk("disabled_locked", 32'(locked), 32'd0);
    chk("disabled_edge_pulse", 32'(edge_pulse), 32'd0);
    chk("disabled_timeout", 32'(timeout), 32'd0);
    for (int p = 0; p < 6; p++) wave(1500, 60, 100, 90, 1'b0);

    // reset pulsed mid-stream, in the middle of a high phase
    for (int i = 0; i < 30; i++) tick(1500, 1'b1, 1'b0);
    pulse_reset("midreset");
    for (int i = 0; i < 5; i++) tick(1500, 1'b1, 1'b0);
    chk("no_strobe_after_reset", 32'(edge_pulse), 32'd0);
    for (int i = 0; i < 40; i++) tick(100, 1'b1, 1'b0);
    for (int p = 0; p < 6; p++) wave(1500, 60, 100, 90, 1'b0);
    chk("relocked_after_reset", 32'(locked), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
